// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and
// register-file geometry constants.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_e;

  localparam int REG_W_DEF = 4;
  // PC is architecturally r15 but is compared like any other register.
  localparam int PC_REG    = 15;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is a
// source actually read by the instruction in ID.
module hazard_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit   = id_uses_rn && (id_rn == ex_rd);
    rm_hit   = id_uses_rm && (id_rm == ex_rd);
    load_use = ex_mem_read && (rn_hit || rm_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: memory wait handling,
// taken-branch flush and load-use interlock, plus a saturating stall counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_W       = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_fault,
  output logic [15:0]      stall_cycles
);

  hz_state_e   state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use;
  logic        pipe_go;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pipe_go    = 1'b0;
    mem_req    = 1'b0;
    if_en      = 1'b0;
    id_en      = 1'b0;
    ex_en      = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    mem_fault  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_access) begin
          mem_req = 1'b1;
          if (mem_ready) pipe_go = 1'b1;
          else           state_d = MEM_WAIT;
        end else begin
          pipe_go = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req    = 1'b1;
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (mem_ready) begin
          pipe_go    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_d == 8'(MEM_TIMEOUT)) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        mem_fault = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Memory rule satisfied: the branch and load-use rules decide this cycle.
    if (pipe_go) begin
      if (ex_branch_taken) begin
        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end else if (load_use) begin
        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b00111;
        ex_flush = 1'b1;
      end else begin
        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
      end
    end

    if (reset) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      mem_req    = 1'b0;
      {if_en, id_en, ex_en, mem_en, wb_en} = 5'b00000;
      id_flush   = 1'b1;
      ex_flush   = 1'b1;
      mem_fault  = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (reset)                              stall_d = 16'd0;
    else if (!if_en && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    stall_cycles = reset ? 16'd0 : stall_q;
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wait_cnt_q <= wait_cnt_d;
    stall_q    <= stall_d;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage ARM pipeline. Watches the ID, EX and MEM stages and drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards: load-use dependencies, taken-branch flushes, and multicycle data-memory accesses. Memory accesses use a request/ready handshake with a timeout fault.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready before fault (1..255)
- REG_W, 4: register address width
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- id_rn, id_rm  input  REG_W  source registers of the instruction in ID
- id_uses_rn, id_uses_rm  input  1  the corresponding source is actually read
- ex_mem_read  input  1  instruction in EX is a load
- ex_rd  input  REG_W  destination of the instruction in EX
- ex_branch_taken  input  1  branch resolved taken in EX
- mem_access  input  1  instruction in MEM performs a load or store
- mem_ready  input  1  data memory completes the access this cycle
- mem_req  output  1  data memory request
- if_en, id_en, ex_en, mem_en, wb_en  output  1  stage register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
- id_flush, ex_flush  output  1  load a bubble into IF/ID and ID/EX respectively
- mem_fault  output  1  sticky memory-timeout fault
- stall_cycles  output  16  saturating count of cycles with if_en=0

## Operation
- States: RUN, MEM_WAIT, FAULT.
- Reset: state RUN and wait counter 0.
  - Outputs while reset is high: all enables 0, id_flush=ex_flush=1, mem_req=0, mem_fault=0, stall_cycles=0.
- RUN, priority from highest to lowest:
  1. Memory: if mem_access and !mem_ready, then mem_req=1, all enables 0, flushes 0, and the next state is MEM_WAIT. If mem_access and mem_ready, then mem_req=1 and the pipeline advances normally.
  2. Branch: if ex_branch_taken, all enables 1 and id_flush=ex_flush=1.
  3. Load-use: fires when ex_mem_read and ex_rd matches a source that is used (id_uses_rn with id_rn==ex_rd, or id_uses_rm with id_rm==ex_rd).
     - Outputs: if_en=id_en=0, ex_flush=1, mem_en=wb_en=1.
     - Lasts exactly one cycle, because the load moves to MEM.
  4. Otherwise all enables 1 and flushes 0.
- Branch and load-use in the same cycle: the branch wins and no stall occurs.
- MEM_WAIT:
  - mem_req is held at 1.
  - The wait counter increments every cycle.
  - All enables are 0 until mem_ready is seen.
  - On mem_ready: the outputs for that cycle are the RUN-rule outputs with the memory rule satisfied, so the branch and load-use rules apply in that cycle. Next state is RUN and the counter clears.
  - If the counter reaches MEM_TIMEOUT without mem_ready: next state is FAULT.
- FAULT: all enables 0, flushes 0, mem_req=0, mem_fault=1. The block stays in FAULT until reset.
- stall_cycles: increments in every non-reset cycle where if_en=0, including FAULT. It saturates at 0xFFFF.
- Register 15 (PC) is compared like any other register. The block applies no special case for it.

## Timing
- Hazard detection is combinational. Stalls and flushes take effect in the same cycle the condition is present.
- Zero-wait memory (mem_ready high together with mem_access) causes no stall.
- N-wait memory access freezes the pipeline for exactly N cycles. The enables rise in the cycle mem_ready is high.
- Timeout: with mem_ready never asserted, the block enters FAULT after MEM_TIMEOUT cycles in MEM_WAIT. mem_fault rises on the following cycle.
- Reset mid-MEM_WAIT: the next cycle is in RUN with the counter at 0. The pending access is abandoned and mem_req drops.
- mem_ready outside MEM_WAIT without mem_access is ignored.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN, MEM_WAIT, FAULT);
  - the REG_W default;
  - the PC register index constant (15).
- One sub-module, hazard_detect: a purely combinational load-use comparator that outputs a single load_use bit.
- The FSM, wait counter, priority logic and stall counter stay in the top module.

## Test plan
- Load r3 in EX, ID reads r3 via rm with id_uses_rm=1: one cycle of if_en=id_en=0 and ex_flush=1, then normal. With id_uses_rm=0 there is no stall.
- ex_branch_taken=1 in the same cycle as a load-use match on r5: id_flush=ex_flush=1, all enables 1, stall_cycles unchanged.
- mem_access with mem_ready low for 3 cycles, then high: enables 0 for 3 cycles, mem_req high 4 cycles, stall_cycles +3.
- mem_access with mem_ready never asserted, MEM_TIMEOUT=15: FAULT entered, mem_fault=1 and held, enables 0 until reset.
- Reset asserted in the 2nd cycle of MEM_WAIT:
  - during reset, id_flush=ex_flush=1 and mem_req=0;
  - after release, the state is RUN with stall_cycles=0.
- Zero-wait access (mem_access=mem_ready=1) back-to-back for 4 cycles: all enables 1, no state change.
